dlink_frame_serializer: RTL

// Parametrised digital-downlink serializer, next generation of the channel 34/35 downlink logic.
// CPU writes NWORDS holding registers; a telemetry start pulse snapshots them into a shift buffer.

---
 rtl/dlink_frame_serializer_if.sv | 33 +++
 rtl/dlink_frame_serializer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dlink_frame_serializer_if.sv
// dlink_frame_serializer_if: CPU write port, telemetry controls
// and serial/status outputs of the downlink frame serializer.
interface dlink_frame_serializer_if #(
  parameter int WORD_W = 15,
  parameter int NWORDS = 2
);
  localparam int SELW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic              wr_;
  logic [SELW-1:0]   wr_sel;
  logic [WORD_W-1:0] wr_data;
  logic              ordr;
  logic              dlkclr;
  logic              dkstrt;
  logic              dkbsnc;
  logic              dkend;
  logic              dkdata;
  logic              busy;
  logic              dlkint;
  logic              trunc;

  modport master (
    output wr_, wr_sel, wr_data, ordr,
    output dlkclr, dkstrt, dkbsnc, dkend,
    input  dkdata, busy, dlkint, trunc
  );

  modport slave (
    input  wr_, wr_sel, wr_data, ordr,
    input  dlkclr, dkstrt, dkbsnc, dkend,
    output dkdata, busy, dlkint, trunc
  );
endinterface

// File: rtl/dlink_frame_serializer.sv
// dlink_frame_serializer: holding regs snapshot into a bit-sync shifter.
// Define DLINK_PARITY_EN to append an odd-parity bit to every word.
module dlink_frame_serializer #(
  parameter int WORD_W = 15,
  parameter int NWORDS = 2
) (
  input logic clk,
  input logic rst_,
  dlink_frame_serializer_if.slave bus
);

`ifdef DLINK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int SELW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BPW   = WORD_W + 1 + PAR;
  localparam int FBITS = NWORDS * BPW;
  localparam int CW    = $clog2(FBITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SHIFT
  } state_t;

  state_t st, nxt;

  logic [WORD_W-1:0] hold [NWORDS];
  logic [FBITS-1:0]  sbuf;
  logic [FBITS-1:0]  frame;
  logic [BPW-1:0]    word;
  logic              ob;
  logic [CW-1:0]     cnt;
  logic              dkdata_q;
  logic              dlkint_q;
  logic              trunc_q;

  logic active, kill, last;
  logic load, shift, done, abort;

  assign bus.dkdata = dkdata_q;
  assign bus.dlkint = dlkint_q;
  assign bus.trunc  = trunc_q;
  assign bus.busy   = active;

  // Word 0 leads the frame; each word sends order bit, then data MSB first.
  always_comb begin
    frame = '0;
    word  = '0;
    ob    = 1'b0;
    for (int w = 0; w < NWORDS; w++) begin
      ob = (w == 0) ? bus.ordr : 1'b0;
`ifdef DLINK_PARITY_EN
      word = {ob, hold[w], ~^{ob, hold[w]}};
`else
      word = {ob, hold[w]};
`endif
      frame[(NWORDS-1-w)*BPW +: BPW] = word;
    end
  end

  assign active = (st != IDLE);
  assign kill   = bus.dlkclr | bus.dkend;
  assign last   = (st == SHIFT) && (cnt == CW'(FBITS));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) st <= IDLE;
    else       st <= nxt;
  end

  always_comb begin
    nxt   = st;
    load  = 1'b0;
    shift = 1'b0;
    done  = 1'b0;
    abort = 1'b0;
    unique case (1'b1)
      (active && kill): begin
        abort = 1'b1;
        nxt   = IDLE;
      end
      (active && !kill && bus.dkbsnc && last): begin
        done = 1'b1;
        nxt  = IDLE;
      end
      (active && !kill && bus.dkbsnc && !last): begin
        shift = 1'b1;
        nxt   = SHIFT;
      end
      (!active && !bus.dlkclr && bus.dkstrt): begin
        load = 1'b1;
        nxt  = ARM;
      end
      default: ;
    endcase
  end

  // Clear beats a coincident write.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int w = 0; w < NWORDS; w++) hold[w] <= '0;
    end else if (bus.dlkclr) begin
      for (int w = 0; w < NWORDS; w++) hold[w] <= '0;
    end else if (!bus.wr_) begin
      for (int w = 0; w < NWORDS; w++) begin
        if (bus.wr_sel == SELW'(w)) hold[w] <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sbuf     <= '0;
      cnt      <= '0;
      dkdata_q <= 1'b0;
      dlkint_q <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      dlkint_q <= done;
      if (load) begin
        sbuf    <= frame;
        cnt     <= '0;
        trunc_q <= 1'b0;
      end
      if (shift) begin
        dkdata_q <= sbuf[FBITS-1];
        sbuf     <= sbuf << 1;
        cnt      <= cnt + CW'(1);
      end
      if (done || abort) dkdata_q <= 1'b0;
      if (abort) trunc_q <= 1'b1;
    end
  end

endmodule
